// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// seven_seg_scan_ctrl: frame-snapshot scan controller for a multiplexed common-cathode 7-segment display.
// Optional leading-zero blanking is enabled with `define SEVEN_SEG_LZB_EN.
module seven_seg_scan_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 1000,
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk50MHz,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            Segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     SEL,
  output logic [2:0]            digit_idx,
  output logic                  frame_done
);

  localparam int             SLOT       = CLK_HZ / SCAN_HZ;
  localparam int             CW         = $clog2(SLOT);
  localparam logic [CW-1:0]  C_LAST_CNT = CW'(SLOT - 1);
  localparam logic [CW-1:0]  C_BLANK    = CW'(BLANK_CYCLES);
  localparam logic [2:0]     C_LAST_DIG = 3'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [2:0]            r_idx, w_idx_nxt;
  logic                  w_cap;
  logic [4*DIGITS-1:0]   r_val, w_val_nxt;
  logic [DIGITS-1:0]     r_dps, w_dps_nxt;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_vis;
  logic [6:0]            r_seg, w_seg_nxt;
  logic                  r_dp, w_dp_nxt;
  logic [DIGITS-1:0]     r_sel, w_sel_nxt;
  logic                  r_fd, w_fd_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_LZB_EN
  logic [2:0] r_hi, w_hi_nxt;

  // A digit with its decimal point requested counts as significant.
  function automatic logic [2:0] f_highest(input logic [4*DIGITS-1:0] v,
                                           input logic [DIGITS-1:0]   d);
    logic [2:0] h;
    h = 3'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((v[4*k +: 4] != 4'd0) || d[k]) h = 3'(k);
    end
    return h;
  endfunction

  assign w_hi_nxt = w_cap ? f_highest(value, dp_in) : r_hi;
  assign w_vis    = (w_idx_nxt <= w_hi_nxt);

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) r_hi <= 3'd0;
    else        r_hi <= w_hi_nxt;
  end
`else
  assign w_vis = 1'b1;
`endif

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_cap       = 1'b0;
    w_cnt_inc   = r_cnt + CW'(1);
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_state_nxt = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
        end
        default: begin
          if (r_cnt == C_LAST_CNT) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
            if (r_idx == C_LAST_DIG) begin
              w_idx_nxt = 3'd0;
              w_cap     = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc >= C_BLANK) ? S_SHOW : S_BLANK;
          end
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register on the transition edge.
  always_comb begin
    w_val_nxt = w_cap ? value : r_val;
    w_dps_nxt = w_cap ? dp_in : r_dps;
    w_nib     = 4'd0;
    w_dp_bit  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_nxt == 3'(k)) begin
        w_nib    = w_val_nxt[4*k +: 4];
        w_dp_bit = w_dps_nxt[k];
      end
    end
    w_seg_nxt = 7'd0;
    w_dp_nxt  = 1'b0;
    w_sel_nxt = '1;
    if ((w_state_nxt == S_SHOW) && w_vis) begin
      w_seg_nxt = f_decode(w_nib);
      w_dp_nxt  = w_dp_bit;
      for (int k = 0; k < DIGITS; k++) begin
        w_sel_nxt[k] = (w_idx_nxt != 3'(k));
      end
    end
    w_fd_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt == C_LAST_CNT) &&
               (w_idx_nxt == C_LAST_DIG);
  end

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_val <= '0;
      r_dps <= '0;
      r_seg <= 7'd0;
      r_dp  <= 1'b0;
      r_sel <= '1;
      r_fd  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_val <= w_val_nxt;
      r_dps <= w_dps_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
      r_sel <= w_sel_nxt;
      r_fd  <= w_fd_nxt;
    end
  end

  assign Segments   = r_seg;
  assign dp         = r_dp;
  assign SEL        = r_sel;
  assign digit_idx  = r_idx;
  assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// tb_seven_seg_scan_ctrl: scoreboard bench; expected outputs come from a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int DIGITS  = 4;
  localparam int BLANK   = 2;
  localparam int SLOT    = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = SLOT * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  SEL;
  logic [2:0]  digit_idx;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(DIGITS), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk50MHz(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .Segments(Segments), .dp(dp), .SEL(SEL), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [6:0]  seg_tab [16];

  // Reference model: position within the current frame plus the frame's snapshot.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp = 4'h0;

  logic [15:0] rv = 16'h0;
  logic [15:0] rmask = 16'hFFFF;
  logic [3:0]  rd = 4'h0;
  logic        ren = 1'b1;

  function automatic exp_t model_out();
    exp_t e;
    int slot, pos, hi;
    logic [3:0] nib;
    e.seg = 7'h00; e.dp = 1'b0; e.sel = 4'hF; e.idx = 3'd0; e.fd = 1'b0;
    if (m_run) begin
      slot  = m_t / SLOT;
      pos   = m_t % SLOT;
      e.idx = 3'(slot);
      e.fd  = (m_t == FRAME - 1);
      hi    = DIGITS - 1;
`ifdef SEVEN_SEG_LZB_EN
      hi = 0;
      for (int k = 0; k < DIGITS; k++)
        if ((((m_val >> (4*k)) & 16'hF) != 16'h0) || m_dp[k]) hi = k;
`endif
      if (pos >= BLANK && slot <= hi) begin
        nib   = 4'((m_val >> (4*slot)) & 16'hF);
        e.seg = seg_tab[nib];
        e.dp  = m_dp[slot];
        e.sel = 4'(~(4'd1 << slot));
      end
    end
    return e;
  endfunction

  task automatic drive(input logic rn, input logic en, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    if (!rn && rst_n) begin
      rst_n = 1'b0;
      #1;
      checks++;
      if (Segments != 7'h00 || SEL != 4'hF || dp != 1'b0 || frame_done != 1'b0 || digit_idx != 3'd0) begin
        failures++;
        $display("FAIL async_reset: got seg=%h dp=%b sel=%b idx=%0d fd=%b, want seg=00 dp=0 sel=1111 idx=0 fd=0",
                 Segments, dp, SEL, digit_idx, frame_done);
      end
    end
    rst_n  = rn;
    enable = en;
    value  = v;
    dp_in  = d;
    if (!rn || !en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0; m_val = v; m_dp = d;
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t = 0; m_val = v; m_dp = d;
      end
    end
    exp_q.push_back(model_out());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (Segments != mon_e.seg || dp != mon_e.dp || SEL != mon_e.sel ||
            digit_idx != mon_e.idx || frame_done != mon_e.fd) begin
          failures++;
          $display("FAIL scan_out @%0t: got seg=%h dp=%b sel=%b idx=%0d fd=%b, want seg=%h dp=%b sel=%b idx=%0d fd=%b",
                   $time, Segments, dp, SEL, digit_idx, frame_done,
                   mon_e.seg, mon_e.dp, mon_e.sel, mon_e.idx, mon_e.fd);
        end
      end
    end
  end

  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;

    repeat (5)  drive(1'b0, 1'b0, 16'h0000, 4'h0);
    repeat (5)  drive(1'b1, 1'b0, 16'h1A3F, 4'b0100);
    repeat (80) drive(1'b1, 1'b1, 16'h1A3F, 4'b0100);

    // Change the value at the start of slot 2: no tearing until the next frame.
    for (int i = 0; i < FRAME && m_t != 19; i++) drive(1'b1, 1'b1, 16'h1A3F, 4'b0100);
    repeat (60) drive(1'b1, 1'b1, 16'h2222, 4'b0000);

    // Drop enable during the SHOW phase of digit 1, then restart.
    for (int i = 0; i < FRAME && m_t != 14; i++) drive(1'b1, 1'b1, 16'h2222, 4'b0000);
    drive(1'b1, 1'b0, 16'h2222, 4'b0000);
    repeat (15) drive(1'b1, 1'b1, 16'h1A3F, 4'b0100);

    // Asynchronous reset while digit 2 is lit.
    for (int i = 0; i < FRAME && m_t != 25; i++) drive(1'b1, 1'b1, 16'h1A3F, 4'b0100);
    repeat (3)  drive(1'b0, 1'b1, 16'h1A3F, 4'b0100);
    repeat (45) drive(1'b1, 1'b1, 16'h1A3F, 4'b0100);

    // Leading-zero patterns and a decimal point on a leading digit.
    drive(1'b1, 1'b0, 16'h0050, 4'h0);
    repeat (45) drive(1'b1, 1'b1, 16'h0050, 4'h0);
    drive(1'b1, 1'b0, 16'h0000, 4'h0);
    repeat (45) drive(1'b1, 1'b1, 16'h0000, 4'h0);
    drive(1'b1, 1'b0, 16'h0005, 4'b1000);
    repeat (45) drive(1'b1, 1'b1, 16'h0005, 4'b1000);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rmask = 16'hFFFF;
          1: rmask = 16'h00FF;
          2: rmask = 16'h000F;
          default: rmask = 16'h0000;
        endcase
        rv = 16'($urandom) & rmask;
      end
      if ($urandom_range(0, 15) == 0) rd = 4'($urandom);
      ren = ($urandom_range(0, 63) != 0);
      drive(1'b1, ren, rv, rd);
    end

    repeat (3) drive(1'b1, 1'b0, 16'h0000, 4'h0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
